// File: rtl/decode_stage_pipe.sv
// RV32I decode stage: registered decode into a 2-entry skid buffer with valid/ready on both sides.
// The bundle is driven only from the head entry, so no combinational path runs from in_ir to the outputs.
module decode_stage_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] HALT_INSN = 32'h0000_0073,
  parameter bit          SKID      = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_ir,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      srcreg1_num,
  output logic [4:0]      srcreg2_num,
  output logic [4:0]      dstreg_num,
  output logic [XLEN-1:0] imm,
  output logic [5:0]      alucode,
  output logic [1:0]      aluop1_type,
  output logic [1:0]      aluop2_type,
  output logic            reg_we,
  output logic            is_load,
  output logic            is_store,
  output logic            is_halt,
  output logic            is_illegal
);

  localparam logic [5:0] ALU_LUI  = 6'd0,  ALU_JAL  = 6'd1,  ALU_JALR = 6'd2,  ALU_BEQ  = 6'd3;
  localparam logic [5:0] ALU_BNE  = 6'd4,  ALU_BLT  = 6'd5,  ALU_BGE  = 6'd6,  ALU_BLTU = 6'd7;
  localparam logic [5:0] ALU_BGEU = 6'd8,  ALU_LB   = 6'd9,  ALU_LH   = 6'd10, ALU_LW   = 6'd11;
  localparam logic [5:0] ALU_LBU  = 6'd12, ALU_LHU  = 6'd13, ALU_SB   = 6'd14, ALU_SH   = 6'd15;
  localparam logic [5:0] ALU_SW   = 6'd16, ALU_ADD  = 6'd17, ALU_SUB  = 6'd18, ALU_SLT  = 6'd19;
  localparam logic [5:0] ALU_SLTU = 6'd20, ALU_XOR  = 6'd21, ALU_OR   = 6'd22, ALU_AND  = 6'd23;
  localparam logic [5:0] ALU_SLL  = 6'd24, ALU_SRL  = 6'd25, ALU_SRA  = 6'd26, ALU_NOP  = 6'd63;

  localparam logic [1:0] OP_TYPE_NONE = 2'd0, OP_TYPE_REG = 2'd1, OP_TYPE_IMM = 2'd2, OP_TYPE_PC = 2'd3;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011, OPC_OPIMM  = 7'b0010011, OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_OP     = 7'b0110011, OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_BR    = 7'b1100011, OPC_JALR   = 7'b1100111, OPC_JAL   = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [5:0]      alucode;
    logic [1:0]      op1;
    logic [1:0]      op2;
    logic            reg_we;
    logic            is_load;
    logic            is_store;
    logic            is_halt;
    logic            is_illegal;
  } bundle_t;

  // Shared ALU mapping for OP and OP-IMM; alt selects SUB/SRA
  function automatic logic [5:0] arith_code(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    arith_code = alt ? ALU_SUB : ALU_ADD;
      3'd1:    arith_code = ALU_SLL;
      3'd2:    arith_code = ALU_SLT;
      3'd3:    arith_code = ALU_SLTU;
      3'd4:    arith_code = ALU_XOR;
      3'd5:    arith_code = alt ? ALU_SRA : ALU_SRL;
      3'd6:    arith_code = ALU_OR;
      default: arith_code = ALU_AND;
    endcase
  endfunction

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  logic        ill, wr_rd, use_shamt;
  bundle_t     dec, rst_bundle;
  bundle_t     e0_q, e0_d, e1_q, e1_d;
  logic        v0_q, v0_d, v1_q, v1_d;
  logic        acc, ret;

  assign opc   = in_ir[6:0];
  assign f3    = in_ir[14:12];
  assign f7    = in_ir[31:25];
  assign rs1   = in_ir[19:15];
  assign rs2   = in_ir[24:20];
  assign rd    = in_ir[11:7];
  assign imm_i = {{20{in_ir[31]}}, in_ir[31:20]};
  assign imm_s = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
  assign imm_b = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
  assign imm_u = {in_ir[31:12], 12'd0};
  assign imm_j = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};

  // Instruction decode of the incoming word
  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.alucode = ALU_NOP;
    imm32       = 32'd0;
    ill         = 1'b0;
    wr_rd       = 1'b0;
    use_shamt   = 1'b0;
    case (opc)
      OPC_OPIMM: begin
        dec.rs1 = rs1; dec.rd = rd; dec.op1 = OP_TYPE_REG; dec.op2 = OP_TYPE_IMM;
        wr_rd = 1'b1; imm32 = imm_i;
        dec.alucode = arith_code(f3, (f3 == 3'd5) && in_ir[30]);
        if (f3 == 3'd1) begin
          use_shamt = 1'b1; ill = (f7 != 7'h00);
        end else if (f3 == 3'd5) begin
          use_shamt = 1'b1; ill = (f7 != 7'h00) && (f7 != 7'h20);
        end
      end
      OPC_OP: begin
        dec.rs1 = rs1; dec.rs2 = rs2; dec.rd = rd; dec.op1 = OP_TYPE_REG; dec.op2 = OP_TYPE_REG;
        wr_rd = 1'b1;
        dec.alucode = arith_code(f3, in_ir[30]);
        ill = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      OPC_LUI: begin
        dec.rd = rd; dec.op1 = OP_TYPE_NONE; dec.op2 = OP_TYPE_IMM; dec.alucode = ALU_LUI;
        wr_rd = 1'b1; imm32 = imm_u;
      end
      OPC_AUIPC: begin
        dec.rd = rd; dec.op1 = OP_TYPE_IMM; dec.op2 = OP_TYPE_PC; dec.alucode = ALU_ADD;
        wr_rd = 1'b1; imm32 = imm_u;
      end
      OPC_JAL: begin
        dec.rd = rd; dec.op1 = OP_TYPE_NONE; dec.op2 = OP_TYPE_PC; dec.alucode = ALU_JAL;
        wr_rd = 1'b1; imm32 = imm_j;
      end
      OPC_JALR: begin
        dec.rs1 = rs1; dec.rd = rd; dec.op1 = OP_TYPE_REG; dec.op2 = OP_TYPE_PC;
        dec.alucode = ALU_JALR; wr_rd = 1'b1; imm32 = imm_i;
      end
      OPC_BR: begin
        dec.rs1 = rs1; dec.rs2 = rs2; dec.op1 = OP_TYPE_REG; dec.op2 = OP_TYPE_REG; imm32 = imm_b;
        case (f3)
          3'd0:    dec.alucode = ALU_BEQ;
          3'd1:    dec.alucode = ALU_BNE;
          3'd4:    dec.alucode = ALU_BLT;
          3'd5:    dec.alucode = ALU_BGE;
          3'd6:    dec.alucode = ALU_BLTU;
          3'd7:    dec.alucode = ALU_BGEU;
          default: ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.rs1 = rs1; dec.rs2 = rs2; dec.op1 = OP_TYPE_REG; dec.op2 = OP_TYPE_IMM;
        dec.is_store = 1'b1; imm32 = imm_s;
        case (f3)
          3'd0:    dec.alucode = ALU_SB;
          3'd1:    dec.alucode = ALU_SH;
          3'd2:    dec.alucode = ALU_SW;
          default: ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.rs1 = rs1; dec.rd = rd; dec.op1 = OP_TYPE_REG; dec.op2 = OP_TYPE_IMM;
        dec.is_load = 1'b1; wr_rd = 1'b1; imm32 = imm_i;
        case (f3)
          3'd0:    dec.alucode = ALU_LB;
          3'd1:    dec.alucode = ALU_LH;
          3'd2:    dec.alucode = ALU_LW;
          3'd4:    dec.alucode = ALU_LBU;
          3'd5:    dec.alucode = ALU_LHU;
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    if (in_ir[1:0] != 2'b11) ill = 1'b1;
    // The halt word is never illegal and never writes a register
    if (in_ir == HALT_INSN) begin
      dec.is_halt = 1'b1; ill = 1'b0; wr_rd = 1'b0;
    end
    dec.imm    = use_shamt ? XLEN'(in_ir[24:20]) : XLEN'($signed(imm32));
    dec.reg_we = wr_rd && (rd != 5'd0);
    if (ill) begin
      dec            = '0;
      dec.pc         = in_pc;
      dec.alucode    = ALU_NOP;
      dec.is_illegal = 1'b1;
    end
  end

  always_comb begin
    rst_bundle         = '0;
    rst_bundle.alucode = ALU_NOP;
  end

  assign in_ready = SKID ? !v1_q : (!v0_q || out_ready);
  assign acc      = in_valid && in_ready && !flush;
  assign ret      = v0_q && out_ready;

  // Skid buffer: retire shifts entry1 to the head, then the accepted word fills the first free slot
  always_comb begin
    e0_d = e0_q;
    e1_d = e1_q;
    v0_d = v0_q;
    v1_d = v1_q;
    if (ret) begin
      e0_d = e1_q; v0_d = v1_q; v1_d = 1'b0;
    end
    if (acc) begin
      if (!v0_d) begin
        e0_d = dec; v0_d = 1'b1;
      end else begin
        e1_d = dec; v1_d = 1'b1;
      end
    end
    if (flush) begin
      v0_d = 1'b0; v1_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      e0_q <= rst_bundle;
      e1_q <= rst_bundle;
    end else begin
      v0_q <= v0_d;
      v1_q <= v1_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
    end
  end

  assign out_valid   = v0_q;
  assign out_pc      = e0_q.pc;
  assign srcreg1_num = e0_q.rs1;
  assign srcreg2_num = e0_q.rs2;
  assign dstreg_num  = e0_q.rd;
  assign imm         = e0_q.imm;
  assign alucode     = e0_q.alucode;
  assign aluop1_type = e0_q.op1;
  assign aluop2_type = e0_q.op2;
  assign reg_we      = e0_q.reg_we;
  assign is_load     = e0_q.is_load;
  assign is_store    = e0_q.is_store;
  assign is_halt     = e0_q.is_halt;
  assign is_illegal  = e0_q.is_illegal;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios plus a randomized run against a queue-based
// model of a 2-deep in-order buffer with a table-driven RV32I decoder.
module tb_decode_stage_pipe;

  localparam logic [31:0] HALT = 32'h0000_0073;

  localparam logic [5:0] ALU_LUI = 0, ALU_JAL = 1, ALU_JALR = 2, ALU_BEQ = 3, ALU_BNE = 4, ALU_BLT = 5;
  localparam logic [5:0] ALU_BGE = 6, ALU_BLTU = 7, ALU_BGEU = 8, ALU_LB = 9, ALU_LH = 10, ALU_LW = 11;
  localparam logic [5:0] ALU_LBU = 12, ALU_LHU = 13, ALU_SB = 14, ALU_SH = 15, ALU_SW = 16, ALU_ADD = 17;
  localparam logic [5:0] ALU_SUB = 18, ALU_SLT = 19, ALU_SLTU = 20, ALU_XOR = 21, ALU_OR = 22, ALU_AND = 23;
  localparam logic [5:0] ALU_SLL = 24, ALU_SRL = 25, ALU_SRA = 26, ALU_NOP = 63;
  localparam logic [1:0] T_NONE = 0, T_REG = 1, T_IMM = 2, T_PC = 3;

  // funct3-indexed code tables; ALU_NOP marks an illegal funct3
  localparam logic [5:0] T_ARITH [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  localparam logic [5:0] T_BR    [8] = '{ALU_BEQ, ALU_BNE, ALU_NOP, ALU_NOP, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
  localparam logic [5:0] T_LD    [8] = '{ALU_LB, ALU_LH, ALU_LW, ALU_NOP, ALU_LBU, ALU_LHU, ALU_NOP, ALU_NOP};
  localparam logic [5:0] T_ST    [8] = '{ALU_SB, ALU_SH, ALU_SW, ALU_NOP, ALU_NOP, ALU_NOP, ALU_NOP, ALU_NOP};
  localparam logic [6:0] OPS     [9] = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h23, 7'h03};

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [5:0]  alu;
    logic [1:0]  t1, t2;
    logic        we, ld, st, halt, ill;
  } bun_t;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_ir, out_pc, imm;
  logic [4:0]  srcreg1_num, srcreg2_num, dstreg_num;
  logic [5:0]  alucode;
  logic [1:0]  aluop1_type, aluop2_type;
  logic        reg_we, is_load, is_store, is_halt, is_illegal;
  bun_t        obs;
  int          checks, failures;

  decode_stage_pipe #(.XLEN(32), .HALT_INSN(HALT), .SKID(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ir(in_ir), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .srcreg1_num(srcreg1_num), .srcreg2_num(srcreg2_num), .dstreg_num(dstreg_num), .imm(imm),
    .alucode(alucode), .aluop1_type(aluop1_type), .aluop2_type(aluop2_type), .reg_we(reg_we),
    .is_load(is_load), .is_store(is_store), .is_halt(is_halt), .is_illegal(is_illegal)
  );

  assign obs = {out_pc, srcreg1_num, srcreg2_num, dstreg_num, imm, alucode, aluop1_type, aluop2_type,
                reg_we, is_load, is_store, is_halt, is_illegal};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decoder built from field tables and arithmetic immediate extraction
  function automatic bun_t model(input logic [31:0] pc, input logic [31:0] ir);
    bun_t        b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] i_i, i_s, i_b, i_u, i_j;
    bit          writes;
    f3  = ir[14:12];
    f7  = ir[31:25];
    i_i = 32'($signed(ir) >>> 20);
    i_s = (i_i & ~32'd31) | 32'(ir[11:7]);
    i_b = (32'($signed(ir) >>> 19) & ~32'hFFF) | (32'(ir[7]) << 11) | (32'(ir[30:25]) << 5) | (32'(ir[11:8]) << 1);
    i_u = ir & 32'hFFFF_F000;
    i_j = (32'($signed(ir) >>> 11) & 32'hFFF0_0000) | (ir & 32'h000F_F000) | (32'(ir[20]) << 11) | (32'(ir[30:21]) << 1);
    b = '0; b.pc = pc; b.alu = ALU_NOP; writes = 0;
    case (ir[6:0])
      7'h13: begin
        b.rs1 = ir[19:15]; b.rd = ir[11:7]; b.t1 = T_REG; b.t2 = T_IMM; writes = 1; b.alu = T_ARITH[f3];
        if (f3 == 3'd1 || f3 == 3'd5) begin
          b.imm = 32'(ir[24:20]);
          b.ill = !(f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20));
          if (f3 == 3'd5 && f7 == 7'h20) b.alu = ALU_SRA;
        end else b.imm = i_i;
      end
      7'h33: begin
        b.rs1 = ir[19:15]; b.rs2 = ir[24:20]; b.rd = ir[11:7]; b.t1 = T_REG; b.t2 = T_REG; writes = 1;
        b.alu = T_ARITH[f3];
        if (f7 == 7'h20) begin
          if (f3 == 3'd0) b.alu = ALU_SUB; else if (f3 == 3'd5) b.alu = ALU_SRA; else b.ill = 1;
        end else if (f7 != 7'h00) b.ill = 1;
      end
      7'h37: begin b.rd = ir[11:7]; b.t1 = T_NONE; b.t2 = T_IMM; b.alu = ALU_LUI; b.imm = i_u; writes = 1; end
      7'h17: begin b.rd = ir[11:7]; b.t1 = T_IMM; b.t2 = T_PC; b.alu = ALU_ADD; b.imm = i_u; writes = 1; end
      7'h6F: begin b.rd = ir[11:7]; b.t1 = T_NONE; b.t2 = T_PC; b.alu = ALU_JAL; b.imm = i_j; writes = 1; end
      7'h67: begin
        b.rs1 = ir[19:15]; b.rd = ir[11:7]; b.t1 = T_REG; b.t2 = T_PC; b.alu = ALU_JALR; b.imm = i_i; writes = 1;
      end
      7'h63: begin
        b.rs1 = ir[19:15]; b.rs2 = ir[24:20]; b.t1 = T_REG; b.t2 = T_REG; b.imm = i_b;
        b.alu = T_BR[f3]; b.ill = (b.alu == ALU_NOP);
      end
      7'h23: begin
        b.rs1 = ir[19:15]; b.rs2 = ir[24:20]; b.t1 = T_REG; b.t2 = T_IMM; b.imm = i_s; b.st = 1;
        b.alu = T_ST[f3]; b.ill = (b.alu == ALU_NOP);
      end
      7'h03: begin
        b.rs1 = ir[19:15]; b.rd = ir[11:7]; b.t1 = T_REG; b.t2 = T_IMM; b.imm = i_i; b.ld = 1; writes = 1;
        b.alu = T_LD[f3]; b.ill = (b.alu == ALU_NOP);
      end
      default: b.ill = 1;
    endcase
    if (ir == HALT) begin b.halt = 1; b.ill = 0; writes = 0; end
    b.we = writes && (b.rd != 5'd0);
    if (b.ill) begin b.we = 0; b.ld = 0; b.st = 0; b.alu = ALU_NOP; end
    return b;
  endfunction

  // Operand fields of an illegal bundle carry no meaning and are excluded from comparison
  function automatic bun_t care(input bun_t b, input logic ill);
    bun_t r;
    r = b;
    if (ill) begin r.rs1 = '0; r.rs2 = '0; r.rd = '0; r.imm = '0; r.t1 = '0; r.t2 = '0; end
    return r;
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [31:0] ir;
    int          k;
    ir = $urandom;
    k  = $urandom_range(0, 11);
    if (k < 9) ir[6:0] = OPS[k];
    if ($urandom_range(0, 1) == 1) ir[31:25] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20;
    if ($urandom_range(0, 7) == 0) ir[11:7] = 5'd0;
    if (k == 9) ir = HALT;
    return ir;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_ir = 32'h0050_0093; in_pc = 32'h10; out_ready = 1'b0; flush = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (alucode !== ALU_NOP) begin failures++; $display("FAIL reset_alucode got=%0d exp=%0d", alucode, ALU_NOP); end
    checks++;
    if ({out_pc, imm, srcreg1_num, srcreg2_num, dstreg_num, aluop1_type, aluop2_type,
         reg_we, is_load, is_store, is_halt, is_illegal} !== '0) begin
      failures++; $display("FAIL reset_bundle_zero got=%h exp=0", obs);
    end
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_addi();
    in_valid = 1'b1; in_ir = 32'h0050_0093; in_pc = 32'h100; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0b exp=1", out_valid); end
    checks++; if (alucode !== ALU_ADD) begin failures++; $display("FAIL addi_alucode got=%0d exp=%0d", alucode, ALU_ADD); end
    checks++; if (imm !== 32'd5) begin failures++; $display("FAIL addi_imm got=%h exp=5", imm); end
    checks++;
    if (dstreg_num !== 5'd1 || srcreg1_num !== 5'd0 || reg_we !== 1'b1 || is_illegal !== 1'b0) begin
      failures++; $display("FAIL addi_regs got=rd%0d rs1%0d we%0b ill%0b exp=rd1 rs10 we1 ill0",
                           dstreg_num, srcreg1_num, reg_we, is_illegal);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL addi_retired got=%0b exp=0", out_valid); end
  endtask

  task automatic test_back_pressure();
    logic [31:0] got[$];
    int          idx;
    bit          acc;
    out_ready = 1'b0; in_valid = 1'b1; in_ir = 32'h0010_0113;
    in_pc = 32'h0; tick();
    in_pc = 32'h4; tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_drop got=%0b exp=0", in_ready); end
    in_pc = 32'h8; tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_hold got=v%0b pc%h rdy%0b exp=v1 pc0 rdy0", out_valid, out_pc, in_ready);
    end
    out_ready = 1'b1; idx = 2;
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      in_valid = (idx < 4);
      in_pc    = 32'(idx * 4);
      if (out_valid) got.push_back(out_pc);
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    checks++; if (got.size() != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== 32'(i * 4)) begin failures++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, got[i], 32'(i * 4)); end
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%0b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_ir = 32'h0010_0113;
    in_pc = 32'h20; tick();
    in_pc = 32'h24; tick();
    in_pc = 32'h28; flush = 1'b1; tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_empty got=v%0b rdy%0b exp=v0 rdy1", out_valid, in_ready);
    end
    in_pc = 32'h40; tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40) begin
      failures++; $display("FAIL flush_next got=v%0b pc%h exp=v1 pc40", out_valid, out_pc);
    end
    out_ready = 1'b1; tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_alone got=%0b exp=0", out_valid); end
  endtask

  task automatic test_jal_illegal();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h80; in_ir = 32'h0000_006F;
    tick();
    checks++;
    if (reg_we !== 1'b0 || alucode !== ALU_JAL || aluop2_type !== T_PC || is_illegal !== 1'b0) begin
      failures++; $display("FAIL jal_x0 got=we%0b alu%0d t2%0d ill%0b exp=we0 alu%0d t2%0d ill0",
                           reg_we, alucode, aluop2_type, is_illegal, ALU_JAL, T_PC);
    end
    in_pc = 32'h84; in_ir = 32'hFFFF_FFFF;
    tick();
    in_valid = 1'b0;
    checks++;
    if (is_illegal !== 1'b1 || reg_we !== 1'b0 || alucode !== ALU_NOP || out_pc !== 32'h84) begin
      failures++; $display("FAIL illegal_word got=ill%0b we%0b alu%0d pc%h exp=ill1 we0 alu%0d pc84",
                           is_illegal, reg_we, alucode, out_pc, ALU_NOP);
    end
    tick();
  endtask

  task automatic test_halt_sub();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h90; in_ir = HALT;
    tick();
    checks++;
    if (is_halt !== 1'b1 || is_illegal !== 1'b0 || reg_we !== 1'b0) begin
      failures++; $display("FAIL halt got=h%0b ill%0b we%0b exp=h1 ill0 we0", is_halt, is_illegal, reg_we);
    end
    in_pc = 32'h94; in_ir = 32'h4000_0033;
    tick();
    in_valid = 1'b0;
    checks++;
    if (alucode !== ALU_SUB || reg_we !== 1'b0 || is_illegal !== 1'b0 || is_halt !== 1'b0) begin
      failures++; $display("FAIL sub_x0 got=alu%0d we%0b ill%0b h%0b exp=alu%0d we0 ill0 h0",
                           alucode, reg_we, is_illegal, is_halt, ALU_SUB);
    end
    tick();
  endtask

  task automatic test_random();
    bun_t q[$];
    bun_t exp_b, got_b;
    bit   mready;
    flush = 1'b1; in_valid = 1'b0; tick();
    flush = 1'b0;
    for (int c = 0; c < 600; c++) begin
      checks++;
      if (out_valid !== (q.size() > 0)) begin
        failures++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", c, out_valid, q.size() > 0);
      end
      checks++;
      if (in_ready !== (q.size() < 2)) begin
        failures++; $display("FAIL rand_ready cyc=%0d got=%0b exp=%0b", c, in_ready, q.size() < 2);
      end
      if (q.size() > 0) begin
        exp_b = care(q[0], q[0].ill);
        got_b = care(obs, q[0].ill);
        checks++;
        if (got_b !== exp_b) begin
          failures++; $display("FAIL rand_bundle cyc=%0d got=%h exp=%h", c, got_b, exp_b);
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pc     = $urandom & 32'hFFFF_FFFC;
      in_ir     = rand_ir();
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      mready    = (q.size() < 2);
      if (flush) q.delete();
      else begin
        if (out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && mready) q.push_back(model(in_pc, in_ir));
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_ir = '0; out_ready = 1'b0;
    test_reset();
    test_addi();
    test_back_pressure();
    test_flush();
    test_jal_illegal();
    test_halt_sub();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
